// File: rtl/wide_add_pkg.sv
// Shared defaults and FSM encoding for the word-serial wide adder.
package wide_add_pkg;
    localparam int N_DEF     = 32;
    localparam int WORDS_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/FA_param.sv
// Structural N-bit ripple-carry adder built from a chain of full-adder cells.
module FA_param #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_s,
    output logic         o_cout
);
    logic [N:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar gi = 0; gi < N; gi++) begin : g_fa
        assign o_s[gi]    = i_a[gi] ^ i_b[gi] ^ w_c[gi];
        assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
    end

    assign o_cout = w_c[N];
endmodule

// File: rtl/wide_add_seq.sv
// W-bit add/subtract computed one N-bit word per cycle through a single shared ripple adder.
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int WORDS = WORDS_DEF,
    parameter int W     = N * WORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         overflow
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t                  r_state, w_state_nxt;
    logic [WORDS-1:0][N-1:0] r_a, r_b, r_sum;
    logic [IW-1:0]           r_idx;
    logic                    r_carry, r_cout, r_ovf;
    logic [N-1:0]            w_s;
    logic                    w_co, w_last;

    assign w_last = (r_idx == IW'(WORDS - 1));

    FA_param #(.N(N)) u_fa (
        .i_a    (r_a[r_idx]),
        .i_b    (r_b[r_idx]),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_co)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: B is inverted on capture and the +1 rides in as the initial carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_a     <= a;
                    r_b     <= b ^ {W{sub}};
                    r_idx   <= '0;
                    r_carry <= sub;
                end
                S_RUN: begin
                    r_sum[r_idx] <= w_s;
                    r_carry      <= w_co;
                    r_idx        <= r_idx + IW'(1);
                    if (w_last) begin
                        r_cout <= w_co;
                        r_ovf  <= (r_a[WORDS-1][N-1] == r_b[WORDS-1][N-1]) &&
                                  (w_s[N-1] != r_a[WORDS-1][N-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign sum      = r_sum;
    assign c_out    = r_cout;
    assign overflow = r_ovf;
endmodule

// File: tb/tb_wide_add_seq.sv
// Scoreboard bench for wide_add_seq: expected results queued at launch, checked on each done pulse.
module tb_wide_add_seq;
    localparam int N     = 32;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, start, sub;
    logic [W-1:0] a, b;
    logic         busy, done, c_out, overflow;
    logic [W-1:0] sum;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_done = 0;
    bit   prev_done = 1'b0;
    exp_t sb[$];

    wide_add_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .c_out(c_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub);
        logic [W-1:0] bp;
        logic [W:0]   t;
        exp_t         e;
        bp  = msub ? ~mb : mb;
        t   = {1'b0, ma} + {1'b0, bp} + {{W{1'b0}}, msub};
        e.s = t[W-1:0];
        e.c = t[W];
        e.v = (ma[W-1] == bp[W-1]) && (t[W-1] != ma[W-1]);
        return e;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            n_done++;
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL done_unexpected: done=1 with empty scoreboard, sum=%h", sum);
            end else begin
                e = sb.pop_front();
                if ({sum, c_out, overflow} !== e) begin
                    n_fail++;
                    $display("FAIL result: got sum=%h c=%b v=%b exp sum=%h c=%b v=%b",
                             sum, c_out, overflow, e.s, e.c, e.v);
                end
            end
            n_chk++;
            if (prev_done) begin
                n_fail++;
                $display("FAIL done_width: done high 2 cycles, exp 1");
            end
        end
        prev_done = done;
    end

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b1; sub = 1'b0; a = '1; b = '1;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({busy, done, c_out, overflow} !== 4'b0 || sum !== '0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b c=%b v=%b sum=%h exp all 0", busy, done, c_out, overflow, sum);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b exp 0", busy);
        end
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] oa, input logic [W-1:0] ob, input logic osub);
        int   n;
        bit   got;
        exp_t e;
        e = model(oa, ob, osub);
        @(negedge clk);
        a = oa; b = ob; sub = osub; start = 1'b1;
        sb.push_back(e);
        n = 0; got = 0;
        while (n < 20 && !got) begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (done) got = 1;
        end
        n_chk++;
        if (!got || n != WORDS + 1) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles (seen=%0d) exp %0d", nm, n, got, WORDS + 1);
        end
        repeat (3) @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || {sum, c_out, overflow} !== e) begin
            n_fail++;
            $display("FAIL %s hold: busy=%b sum=%h c=%b v=%b exp sum=%h c=%b v=%b",
                     nm, busy, sum, c_out, overflow, e.s, e.c, e.v);
        end
    endtask

    task automatic test_arith();
        logic [W-1:0] x;
        run_op("carry_chain", '1, 1, 1'b0);
        x = '0; x[N-1:0] = '1;
        run_op("word_boundary", x, 1, 1'b0);
        run_op("sub_neg", 5, 7, 1'b1);
        x = '1; x[W-1] = 1'b0;
        run_op("pos_overflow", x, 1, 1'b0);
        x = '0; x[W-1] = 1'b1;
        run_op("sub_overflow", x, 1, 1'b1);
        run_op("sub_equal", 128'h1234, 128'h1234, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++)
            run_op("random", {$urandom, $urandom, $urandom, $urandom},
                   {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
    endtask

    task automatic test_start_while_busy();
        int d0;
        bit got;
        d0 = n_done;
        @(negedge clk);
        a = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210; b = 128'hFFFF_0000_FFFF_0000_1111_2222_3333_4444;
        sub = 1'b0; start = 1'b1;
        sb.push_back(model(a, b, 1'b0));
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        a = '1; b = '1; sub = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        repeat (8) @(negedge clk);
        n_chk++;
        if (n_done - d0 != 1 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL busy_start: got %0d done pulses, %0d pending, exp 1 and 0", n_done - d0, sb.size());
        end
    endtask

    task automatic test_reset_abort();
        int d0;
        d0 = n_done;
        @(negedge clk);
        a = 128'h5555; b = 128'h2222; sub = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || c_out !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: busy=%b done=%b sum=%h c=%b exp 0", busy, done, sum, c_out);
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_chk++;
        if (n_done != d0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d pulses busy=%b exp 0 pulses busy=0", n_done - d0, busy);
        end
    endtask

    task automatic test_back_to_back();
        int d0, n;
        bit got;
        d0 = n_done;
        @(negedge clk);
        a = {$urandom, $urandom, $urandom, $urandom}; b = {$urandom, $urandom, $urandom, $urandom};
        sub = 1'b0; start = 1'b1;
        sb.push_back(model(a, b, sub));
        for (int i = 0; i < 4; i++) begin
            n = 0; got = 0;
            while (n < 20 && !got) begin
                @(negedge clk);
                n++;
                if (done) got = 1;
            end
            n_chk++;
            if (!got || n != ((i == 0) ? WORDS + 1 : WORDS + 2)) begin
                n_fail++;
                $display("FAIL b2b_rate op%0d: got %0d cycles (seen=%0d) exp %0d",
                         i, n, got, (i == 0) ? WORDS + 1 : WORDS + 2);
            end
            if (!got) break;
            if (i < 3) begin
                a = {$urandom, $urandom, $urandom, $urandom}; b = {$urandom, $urandom, $urandom, $urandom};
                sub = 1'(i & 1) ^ 1'b1;
                sb.push_back(model(a, b, sub));
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        repeat (8) @(negedge clk);
        n_chk++;
        if (n_done - d0 != 4 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d pulses, %0d pending, exp 4 and 0", n_done - d0, sb.size());
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        test_reset();
        test_arith();
        test_random();
        test_start_while_busy();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/wide_add_seq.md
WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning the word width of the shared ripple adder.
REQ-002 The block SHALL have parameter WORDS, default 4, meaning the operand length in words (operand width W = N*WORDS).
REQ-003 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide; reset is synchronous and active-high.
REQ-005 Port start SHALL be an input, 1 bit wide, and requests a new operation; it is sampled only in IDLE.
REQ-006 Port sub SHALL be an input, 1 bit wide; 0 selects a+b, 1 selects a-b; it is sampled with start.
REQ-007 Port a SHALL be an input, W bits wide, holding operand A (two's complement, sampled with start).
REQ-008 Port b SHALL be an input, W bits wide, holding operand B (two's complement, sampled with start).
REQ-009 Port busy SHALL be an output, 1 bit wide, high whenever the state is not IDLE.
REQ-010 Port done SHALL be an output, 1 bit wide, giving a one-cycle pulse when the result is valid.
REQ-011 Port sum SHALL be an output, W bits wide, holding the result register.
REQ-012 Port c_out SHALL be an output, 1 bit wide, holding the final carry out of word WORDS-1.
REQ-013 Port overflow SHALL be an output, 1 bit wide, flagging signed overflow of the W-bit result.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 IDLE with start=1 SHALL latch a, sub, and b XOR {W{sub}}; clear the word index to 0; load the carry register with sub; and go to RUN.
REQ-016 IDLE with start=0 SHALL stay in IDLE and change no registers.
REQ-017 Each RUN cycle SHALL drive one N-bit adder with latched word[idx] of A, latched word[idx] of B', and the carry register.
REQ-018 Each RUN cycle SHALL write the adder sum into sum word idx, load the adder carry into the carry register, and increment idx.
REQ-019 RUN with idx=WORDS-1 SHALL capture c_out and overflow and go to DONE.
REQ-020 overflow SHALL equal (A[W-1]==B'[W-1]) AND (sum[W-1]!=A[W-1]).
REQ-021 In subtract mode, c_out=1 SHALL mean no borrow.
REQ-022 DONE SHALL assert done for exactly one cycle, then go to IDLE unconditionally.
REQ-023 Latency SHALL be fixed: start sampled at edge k gives done=1 in the cycle after edge k+WORDS (WORDS+1 cycles).
REQ-024 start while busy (RUN or DONE) SHALL be ignored; it is neither queued nor allowed to corrupt latched operands.
REQ-025 start high in the cycle after done (state IDLE) SHALL be accepted, giving a back-to-back rate of WORDS+2 cycles per operation.
REQ-026 sum, c_out and overflow SHALL hold their values from DONE until the next accepted start.
REQ-027 sum SHALL be guaranteed valid only while done=1 or in IDLE after a completed operation; partial words are visible during RUN.
REQ-028 Exactly one N-bit adder instance SHALL be used; no W-bit combinational adder is permitted.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE and clear idx, the carry register, sum, c_out, overflow, busy and done to 0, with priority over start.
REQ-030 rst during RUN or DONE SHALL abort the operation with no done pulse and discard the latched operands.

Structure
REQ-031 Package wide_add_pkg SHALL hold the default N and WORDS constants and the FSM state enumeration (2-bit encoding).
REQ-032 The index width SHALL be $clog2(WORDS) (minimum 1).
REQ-033 The only sub-module SHALL be the team's structural N-bit ripple adder FA_param, instantiated once with parameter N.

Verification (N=32, WORDS=4)
REQ-034 a=all-ones (128 bits), b=1, sub=0 -> sum=0, c_out=1, overflow=0, done exactly 5 cycles after the start edge.
REQ-035 a=0x0000_0000_0000_0000_0000_0000_FFFF_FFFF, b=1, sub=0 -> sum=0x...0001_0000_0000, carry propagated across a word boundary, c_out=0.
REQ-036 a=5, b=7, sub=1 -> sum=0xFFFF...FFFE, c_out=0, overflow=0.
REQ-037 a=0x7FFF...FFFF, b=1, sub=0 -> sum=0x8000...0000, overflow=1, c_out=0.
REQ-038 start pulsed during RUN with different operands -> first result unchanged and only one done; rst asserted in the second RUN cycle -> busy=0, sum=0, no done.
REQ-039 start held high continuously -> a new operation accepted every 6 cycles, each done pulse one cycle wide, each result correct.
